// File: rtl/mda_hdmi_out.sv
// MDA monochrome pixel stream to parallel RGB/sync/DE for an HDMI transmitter, with
// debounced frame-synchronous palette select and an integer pixel-clock divider.
module mda_hdmi_out #(
   parameter int CH_BITS       = 8,
   parameter int SYNC_DELAY    = 1,
   parameter int DE_DELAY      = 2,
   parameter int CLK_DIV       = 2,
   parameter int DEBOUNCE_BITS = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               video,
   input  logic               intensity,
   input  logic               hsync,
   input  logic               vsync,
   input  logic               display_enable,
   input  logic [1:0]         pal_sel,
   output logic [CH_BITS-1:0] hdmi_r,
   output logic [CH_BITS-1:0] hdmi_g,
   output logic [CH_BITS-1:0] hdmi_b,
   output logic               hdmi_hs,
   output logic               hdmi_vs,
   output logic               hdmi_de,
   output logic               hdmi_clk,
   output logic [1:0]         pal_active
);

   localparam int HALF  = CLK_DIV / 2;
   localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CH_BITS-1:0] LVL_INT  = CH_BITS'((longint'(1) << CH_BITS) - 1);
   localparam logic [CH_BITS-1:0] LVL_NORM = CH_BITS'((((longint'(1) << CH_BITS) - 1) * 2) / 3);

   if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
      $error("mda_hdmi_out: CLK_DIV must be even and >= 2");
   end
   if (SYNC_DELAY < 1 || SYNC_DELAY > 15) begin : g_bad_sync_delay
      $error("mda_hdmi_out: SYNC_DELAY must be 1..15");
   end
   if (DE_DELAY < 1 || DE_DELAY > 15) begin : g_bad_de_delay
      $error("mda_hdmi_out: DE_DELAY must be 1..15");
   end
   if (CH_BITS < 1 || DEBOUNCE_BITS < 1) begin : g_bad_width
      $error("mda_hdmi_out: CH_BITS and DEBOUNCE_BITS must be >= 1");
   end

   logic [1:0]               sel_meta_q, sel_s_q;
   logic [DEBOUNCE_BITS-1:0] deb_cnt_q, deb_cnt_d;
   logic [1:0]               pal_stable_q, pal_stable_d;
   logic [1:0]               pal_active_q, pal_active_d;
   logic                     vs_prev_q;
   logic [SYNC_DELAY-1:0]    hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d;
   logic [DE_DELAY-1:0]      de_sr_q, de_sr_d;
   logic [DIV_W-1:0]         div_q, div_d;
   logic                     clk_div_q, clk_div_d;
   logic [CH_BITS-1:0]       r_q, g_q, b_q, r_d, g_d, b_d;
   logic                     en_r, en_g, en_b;
   logic [CH_BITS-1:0]       lvl;
   logic                     pix_on;

   always_comb begin
      deb_cnt_d    = deb_cnt_q;
      pal_stable_d = pal_stable_q;
      pal_active_d = pal_active_q;
      en_r         = 1'b0;
      en_g         = 1'b1;
      en_b         = 1'b0;
      div_d        = div_q;
      clk_div_d    = clk_div_q;

      // The count restarts on the edge a new value enters sel_s_q, so pal_stable
      // follows 2^DEBOUNCE_BITS-1 edges after the last change of the synchronised switches.
      if (sel_meta_q != sel_s_q) begin
         deb_cnt_d = '0;
      end else if (!(&deb_cnt_q)) begin
         deb_cnt_d = deb_cnt_q + DEBOUNCE_BITS'(1);
      end
      if (&deb_cnt_d) begin
         pal_stable_d = sel_s_q;
      end

      // Frame-boundary apply uses the pre-edge pal_stable, so a same-cycle update waits a frame.
      if (vsync && !vs_prev_q) begin
         pal_active_d = pal_stable_q;
      end

      case (pal_active_q)
         2'd0:    begin en_r = 1'b0; en_g = 1'b1; en_b = 1'b0; end
         2'd1:    begin en_r = 1'b1; en_g = 1'b1; en_b = 1'b0; end
         2'd2:    begin en_r = 1'b1; en_g = 1'b1; en_b = 1'b1; end
         default: begin en_r = 1'b1; en_g = 1'b0; en_b = 1'b0; end
      endcase

      lvl    = intensity ? LVL_INT : LVL_NORM;
      pix_on = video & display_enable;
      r_d    = (pix_on && en_r) ? lvl : '0;
      g_d    = (pix_on && en_g) ? lvl : '0;
      b_d    = (pix_on && en_b) ? lvl : '0;

      hs_sr_d = (hs_sr_q << 1) | SYNC_DELAY'(hsync);
      vs_sr_d = (vs_sr_q << 1) | SYNC_DELAY'(vsync);
      de_sr_d = (de_sr_q << 1) | DE_DELAY'(display_enable);

      if (div_q == DIV_W'(HALF - 1)) begin
         div_d     = '0;
         clk_div_d = ~clk_div_q;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_meta_q   <= '0;
         sel_s_q      <= '0;
         deb_cnt_q    <= '0;
         pal_stable_q <= '0;
         pal_active_q <= '0;
         vs_prev_q    <= 1'b0;
         hs_sr_q      <= '0;
         vs_sr_q      <= '0;
         de_sr_q      <= '0;
         div_q        <= '0;
         clk_div_q    <= 1'b0;
         r_q          <= '0;
         g_q          <= '0;
         b_q          <= '0;
      end else begin
         sel_meta_q   <= pal_sel;
         sel_s_q      <= sel_meta_q;
         deb_cnt_q    <= deb_cnt_d;
         pal_stable_q <= pal_stable_d;
         pal_active_q <= pal_active_d;
         vs_prev_q    <= vsync;
         hs_sr_q      <= hs_sr_d;
         vs_sr_q      <= vs_sr_d;
         de_sr_q      <= de_sr_d;
         div_q        <= div_d;
         clk_div_q    <= clk_div_d;
         r_q          <= r_d;
         g_q          <= g_d;
         b_q          <= b_d;
      end
   end

   assign hdmi_r     = r_q;
   assign hdmi_g     = g_q;
   assign hdmi_b     = b_q;
   assign hdmi_hs    = hs_sr_q[SYNC_DELAY-1];
   assign hdmi_vs    = vs_sr_q[SYNC_DELAY-1];
   assign hdmi_de    = de_sr_q[DE_DELAY-1];
   assign hdmi_clk   = clk_div_q;
   assign pal_active = pal_active_q;

endmodule
